// File: rtl/daa_mac_stream.sv
// daa_mac_stream: streaming radix-4 Booth MAC with dynamic arithmetic alignment (DAA).
// Define DAA_RENORM_EN to enable down-alignment (renormalisation) of the accumulator.
module daa_mac_stream #(
    parameter  int IN_W      = 4,
    parameter  int ACC_W     = 10,
    parameter  int MAX_SHIFT = 7,
    localparam int EXP_W     = $clog2(MAX_SHIFT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_x,
    input  logic                    in_sext,
    input  logic [2:0]              in_w,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic [EXP_W-1:0]        out_exp,
    output logic [MAX_SHIFT-1:0]    out_lsbs,
    output logic                    out_sat
);
    typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [EXP_W-1:0]        EXP_LIM = EXP_W'(MAX_SHIFT);

    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [EXP_W-1:0]        r_exp, w_exp_nxt;
    logic [MAX_SHIFT-1:0]    r_lsbs, w_lsbs_nxt;
    logic                    r_sat, w_sat_nxt;

    logic                    w_accept;
    logic                    w_release;
    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_pp;
    logic signed [ACC_W-1:0] w_ppa;
    logic signed [ACC_W:0]   w_s;
    logic                    w_ovf;

    function automatic logic signed [ACC_W-1:0] saturate(input logic neg);
        return neg ? ACC_MIN : ACC_MAX;
    endfunction

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_HOLD);
    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready;

    // Booth partial product, alignment and one-guard-bit sum
    always_comb begin
        w_x = {{(ACC_W-IN_W){in_sext & in_x[IN_W-1]}}, in_x};
        case (in_w)
            3'b001, 3'b010: w_pp = w_x;
            3'b011:         w_pp = w_x <<< 1;
            3'b100:         w_pp = -(w_x <<< 1);
            3'b101, 3'b110: w_pp = -w_x;
            default:        w_pp = '0;
        endcase
        w_ppa = w_pp >>> r_exp;
        w_s   = {r_acc[ACC_W-1], r_acc} + {w_ppa[ACC_W-1], w_ppa};
        w_ovf = w_s[ACC_W] ^ w_s[ACC_W-1];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_exp_nxt   = r_exp;
        w_lsbs_nxt  = r_lsbs;
        w_sat_nxt   = r_sat;
        if (w_release) begin
            w_state_nxt = ST_ACC;
            w_acc_nxt   = '0;
            w_exp_nxt   = '0;
            w_lsbs_nxt  = '0;
            w_sat_nxt   = 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                w_state_nxt = ST_HOLD;
            end
            if (!w_ovf) begin
                w_acc_nxt = w_s[ACC_W-1:0];
`ifdef DAA_RENORM_EN
                // Headroom of two bits lets the mantissa regain one dropped LSB
                if ((r_exp != '0) && (w_s[ACC_W-1] == w_s[ACC_W-2]) &&
                    (w_s[ACC_W-2] == w_s[ACC_W-3])) begin
                    w_acc_nxt  = {w_s[ACC_W-2:0], r_lsbs[0]};
                    w_exp_nxt  = r_exp - EXP_W'(1);
                    w_lsbs_nxt = r_lsbs >> 1;
                end
`endif
            end else if (r_exp < EXP_LIM) begin
                w_acc_nxt  = w_s[ACC_W:1];
                w_exp_nxt  = r_exp + EXP_W'(1);
                w_lsbs_nxt = MAX_SHIFT'({r_lsbs, w_s[0]});
            end else begin
                w_acc_nxt = saturate(w_s[ACC_W]);
                w_sat_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_exp   <= '0;
            r_lsbs  <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_exp   <= w_exp_nxt;
            r_lsbs  <= w_lsbs_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    assign out_acc  = r_acc;
    assign out_exp  = r_exp;
    assign out_lsbs = r_lsbs;
    assign out_sat  = r_sat;

endmodule
